// File: rtl/pc_update_sequencer.sv
// PC-update sequencer: turns one control request per instruction into PC/EPC write
// strobes, and walks the multi-cycle exception entry (save EPC, read vector, load PC).
module pc_update_sequencer #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] req_kind,
    input  logic       branch_taken,
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_div0,
    output logic [1:0] pc_src_sel,
    output logic       pc_write,
    output logic       epc_write,
    output logic [1:0] vec_sel,
    output logic       mem_rd,
    output logic [1:0] exc_cause,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        EXC_EPC,
        EXC_WAIT,
        EXC_LOAD
    } state_t;

    localparam logic [1:0] SEL_VECTOR = 2'b00;
    localparam logic [1:0] SEL_EPC    = 2'b01;
    localparam logic [1:0] SEL_ALU    = 2'b10;
    localparam logic [1:0] SEL_JUMP   = 2'b11;

    localparam logic [1:0] KIND_SEQ    = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JUMP   = 2'b10;
    localparam logic [1:0] KIND_ERET   = 2'b11;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

    state_t     state, state_next;
    logic [1:0] kind;
    logic       taken;
    logic [3:0] wait_cnt;
    logic [1:0] start_cause;

    // Fixed priority: opcode beats overflow beats div0.
    always_comb begin
        if (exc_opcode)
            start_cause = 2'b01;
        else if (exc_overflow)
            start_cause = 2'b10;
        else if (exc_div0)
            start_cause = 2'b11;
        else
            start_cause = 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // exc_cause persists across normal requests; only a new exception or reset changes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind      <= KIND_SEQ;
            taken     <= 1'b0;
            exc_cause <= 2'b00;
            wait_cnt  <= 4'd0;
        end else begin
            if (state == IDLE && start) begin
                if (start_cause != 2'b00) begin
                    exc_cause <= start_cause;
                end else begin
                    kind  <= req_kind;
                    taken <= branch_taken;
                end
            end
            if (state == EXC_EPC)
                wait_cnt <= WAIT_INIT;
            else if (state == EXC_WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_comb begin
        // NOTE: a default for every combinational output up front means no path
        // through the case can leave a value unassigned and infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (start_cause != 2'b00) ? EXC_EPC : ISSUE;
            end
            ISSUE:    state_next = IDLE;
            EXC_EPC:  state_next = EXC_WAIT;
            EXC_WAIT: begin
                if (wait_cnt == 4'd0)
                    state_next = EXC_LOAD;
            end
            EXC_LOAD: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_src_sel = SEL_ALU;
        pc_write   = 1'b0;
        epc_write  = 1'b0;
        vec_sel    = 2'b00;
        mem_rd     = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            ISSUE: begin
                done = 1'b1;
                case (kind)
                    KIND_SEQ:    begin pc_src_sel = SEL_ALU;  pc_write = 1'b1;  end
                    KIND_BRANCH: begin pc_src_sel = SEL_ALU;  pc_write = taken; end
                    KIND_JUMP:   begin pc_src_sel = SEL_JUMP; pc_write = 1'b1;  end
                    KIND_ERET:   begin pc_src_sel = SEL_EPC;  pc_write = 1'b1;  end
                    default:     pc_src_sel = SEL_ALU;
                endcase
            end
            EXC_EPC: begin
                epc_write = 1'b1;
                vec_sel   = exc_cause;
                mem_rd    = 1'b1;
            end
            EXC_WAIT: begin
                vec_sel = exc_cause;
                mem_rd  = 1'b1;
            end
            EXC_LOAD: begin
                pc_src_sel = SEL_VECTOR;
                pc_write   = 1'b1;
                vec_sel    = exc_cause;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Bench for pc_update_sequencer: random and directed requests, a timeline model
// pushed into a scoreboard, and a per-cycle monitor comparing every output.
module tb_pc_update_sequencer;

    localparam int MEM_LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] req_kind;
    logic       branch_taken;
    logic       exc_opcode;
    logic       exc_overflow;
    logic       exc_div0;
    logic [1:0] pc_src_sel;
    logic       pc_write;
    logic       epc_write;
    logic [1:0] vec_sel;
    logic       mem_rd;
    logic [1:0] exc_cause;
    logic       busy;
    logic       done;

    pc_update_sequencer #(.MEM_LAT(MEM_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .req_kind     (req_kind),
        .branch_taken (branch_taken),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .pc_src_sel   (pc_src_sel),
        .pc_write     (pc_write),
        .epc_write    (epc_write),
        .vec_sel      (vec_sel),
        .mem_rd       (mem_rd),
        .exc_cause    (exc_cause),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One accepted request: when it was sampled and what it must produce.
    typedef struct {
        int         start_cyc;
        int         lat;
        logic [1:0] sel;
        logic       pcw;
        logic [1:0] cause;
        logic       is_exc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         model_done_cyc = -1;
    logic [1:0] exp_cause_hold = 2'b00;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Inputs other than start are don't-care outside an accepted start, so scramble them.
    task automatic idle_inputs();
        start        = 1'b0;
        req_kind     = 2'($urandom);
        branch_taken = 1'($urandom);
        exc_opcode   = 1'($urandom);
        exc_overflow = 1'($urandom);
        exc_div0     = 1'($urandom);
    endtask

    // Drive one start cycle; the model decides whether the DUT is free to accept it.
    task automatic issue(input logic [1:0] k, input logic t, input logic fo,
                         input logic fv, input logic fd);
        exp_t e;
        start        = 1'b1;
        req_kind     = k;
        branch_taken = t;
        exc_opcode   = fo;
        exc_overflow = fv;
        exc_div0     = fd;
        if (cyc > model_done_cyc) begin
            e.start_cyc = cyc;
            e.cause     = fo ? 2'd1 : fv ? 2'd2 : fd ? 2'd3 : 2'd0;
            e.is_exc    = (e.cause != 2'd0);
            if (e.is_exc) begin
                e.lat = 2 + MEM_LAT;
                e.sel = 2'b00;
                e.pcw = 1'b1;
            end else begin
                e.lat = 1;
                case (k)
                    2'd0:    begin e.sel = 2'b10; e.pcw = 1'b1; end
                    2'd1:    begin e.sel = 2'b10; e.pcw = t;    end
                    2'd2:    begin e.sel = 2'b11; e.pcw = 1'b1; end
                    default: begin e.sel = 2'b01; e.pcw = 1'b1; end
                endcase
            end
            model_done_cyc = cyc + e.lat;
            sb.push_back(e);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_idle();
        while (cyc <= model_done_cyc) @(negedge clk);
    endtask

    task automatic sample();
        exp_t       f;
        int         rel;
        logic [1:0] e_sel   = 2'b10;
        logic [1:0] e_vec   = 2'b00;
        logic [1:0] e_cause = exp_cause_hold;
        logic       e_pcw   = 1'b0;
        logic       e_epc   = 1'b0;
        logic       e_mem   = 1'b0;
        logic       e_busy  = 1'b0;
        logic       e_done  = 1'b0;
        bit         pop     = 1'b0;
        if (sb.size() > 0) begin
            f   = sb[0];
            rel = cyc - f.start_cyc;
            if (rel >= 1) e_busy = 1'b1;
            if (f.is_exc && rel >= 1) begin
                e_cause = f.cause;
                e_vec   = f.cause;
            end
            if (f.is_exc && rel == 1) e_epc = 1'b1;
            if (f.is_exc && rel >= 1 && rel <= 1 + MEM_LAT) e_mem = 1'b1;
            if (rel == f.lat) begin
                e_done = 1'b1;
                e_sel  = f.sel;
                e_pcw  = f.pcw;
                pop    = 1'b1;
            end
        end
        check("pc_src_sel", 32'(pc_src_sel), 32'(e_sel));
        check("pc_write",   32'(pc_write),   32'(e_pcw));
        check("epc_write",  32'(epc_write),  32'(e_epc));
        check("vec_sel",    32'(vec_sel),    32'(e_vec));
        check("mem_rd",     32'(mem_rd),     32'(e_mem));
        check("exc_cause",  32'(exc_cause),  32'(e_cause));
        check("busy",       32'(busy),       32'(e_busy));
        check("done",       32'(done),       32'(e_done));
        if (pop) begin
            void'(sb.pop_front());
            if (f.is_exc) exp_cause_hold = f.cause;
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (mon_en) sample();
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("rst pc_src_sel", 32'(pc_src_sel), 32'd2);
        check("rst pc_write",   32'(pc_write),   32'd0);
        check("rst epc_write",  32'(epc_write),  32'd0);
        check("rst vec_sel",    32'(vec_sel),    32'd0);
        check("rst mem_rd",     32'(mem_rd),     32'd0);
        check("rst exc_cause",  32'(exc_cause),  32'd0);
        check("rst busy",       32'(busy),       32'd0);
        check("rst done",       32'(done),       32'd0);
        reset          = 1'b0;
        mon_en         = 1'b1;
        model_done_cyc = cyc;
        @(negedge clk);

        // Directed: each request kind, both branch outcomes, priority, ignored start.
        wait_idle(); issue(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(); issue(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(); issue(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(); issue(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(); issue(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(); issue(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle(); issue(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(); issue(2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        issue(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle(); issue(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic, including starts that land while busy.
        repeat (1500) begin
            if ($urandom_range(0, 2) == 0)
                issue(2'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0));
            else
                @(negedge clk);
        end

        // Reset in the middle of the vector wait abandons the entry and clears the cause.
        wait_idle(); issue(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        exp_cause_hold = 2'b00;
        model_done_cyc = cyc + 1;
        @(negedge clk);
        check("reset busy",      32'(busy),      32'd0);
        check("reset mem_rd",    32'(mem_rd),    32'd0);
        check("reset exc_cause", 32'(exc_cause), 32'd0);
        check("reset pc_write",  32'(pc_write),  32'd0);
        check("reset epc_write", 32'(epc_write), 32'd0);
        reset = 1'b0;

        wait_idle(); issue(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
